alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_if.sv | 39 +++
 rtl/alu_op_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the operation requester and the ALU operation sequencer.
//
// Handshake: a request is start=1 with op/opa/opb valid in the same cycle.
// The sequencer takes it on the next rising edge only while busy=0. While
// busy=1 every request field is ignored. A one-hot op raises busy from the
// following cycle. A non-one-hot op pulses err for one cycle instead. Each
// accepted op ends with exactly one done pulse, in the cycle right after busy
// drops.
interface alu_op_sequencer_if;
    logic        start;
    logic [11:0] op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [11:0] alu_ctrl;
    logic [31:0] zlow_in;
    logic [31:0] zhigh_in;
    logic [31:0] zlow;
    logic [31:0] zhigh;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        err;
    logic        dbg_state;   // 0 = IDLE, 1 = SETTLE

    modport master (
        output start, op, opa, opb, zlow_in, zhigh_in,
        input  alu_a, alu_b, alu_ctrl, zlow, zhigh, hi, lo,
        input  busy, done, err, dbg_state
    );

    modport slave (
        input  start, op, opa, opb, zlow_in, zhigh_in,
        output alu_a, alu_b, alu_ctrl, zlow, zhigh, hi, lo,
        output busy, done, err, dbg_state
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time. It latches the operands and the
// one-hot control. It then waits a per-op number of settle cycles and captures
// the combinational ALU result into Z. MUL and DIV also write the result into
// HI/LO.
module alu_op_sequencer #(
    parameter int MULDIV_CYCLES = 4,
    parameter int BASIC_CYCLES  = 1
) (
    input logic               clock,
    input logic               clear,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // A settle count of zero makes no sense, so it behaves as one cycle.
    localparam int MD_N  = (MULDIV_CYCLES < 1) ? 1 : MULDIV_CYCLES;
    localparam int BA_N  = (BASIC_CYCLES  < 1) ? 1 : BASIC_CYCLES;
    localparam int MAX_N = (MD_N > BA_N) ? MD_N : BA_N;
    // The counter only ever holds N-1.
    localparam int CNT_W = (MAX_N < 2) ? 1 : $clog2(MAX_N);

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_N - 1);
    localparam logic [CNT_W-1:0] BA_LOAD = CNT_W'(BA_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic             op_onehot;
    logic             op_muldiv;
    logic             ctrl_muldiv;
    logic             accept;
    logic             reject;
    logic             capture;

    // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
    assign op_onehot   = (bus.op != 12'd0) && ((bus.op & (bus.op - 12'd1)) == 12'd0);
    assign op_muldiv   = bus.op[2] | bus.op[3];
    assign ctrl_muldiv = bus.alu_ctrl[2] | bus.alu_ctrl[3];

    // Next-state logic plus the accept/reject/capture strobes for the datapath.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (op_onehot) begin
                        accept   = 1'b1;
                        state_nx = SETTLE;
                    end else begin
                        reject   = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (count == '0) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    // Settle counter: loaded with N-1 on accept, counts down to zero in SETTLE.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (accept) begin
            count <= op_muldiv ? MD_LOAD : BA_LOAD;
        end else if ((state == SETTLE) && (count != '0)) begin
            count <= count - CNT_ONE;
        end
    end

    // Operand and control registers change only when an op is accepted.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_ctrl <= '0;
        end else if (accept) begin
            bus.alu_a    <= bus.opa;
            bus.alu_b    <= bus.opb;
            bus.alu_ctrl <= bus.op;
        end
    end

    // Z capture on the last settle edge. HI/LO are written only by MUL and DIV.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus.zlow  <= '0;
            bus.zhigh <= '0;
            bus.hi    <= '0;
            bus.lo    <= '0;
        end else if (capture) begin
            bus.zlow  <= bus.zlow_in;
            bus.zhigh <= bus.zhigh_in;
            if (ctrl_muldiv) begin
                bus.lo <= bus.zlow_in;
                bus.hi <= bus.zhigh_in;
            end
        end
    end

    // One-cycle status pulses. Capture and reject come from different states,
    // so the two pulses can never overlap.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.done <= capture;
            bus.err  <= reject;
        end
    end

    assign bus.busy      = (state == SETTLE);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with default parameters (MUL/DIV settle 4, others 1).
module tb_alu_op_sequencer;

    logic clock = 1'b0;
    logic clear;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .MULDIV_CYCLES (4),
        .BASIC_CYCLES  (1)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " alu_a"},    bus.alu_a,    0);
        check({tag, " alu_b"},    bus.alu_b,    0);
        check({tag, " alu_ctrl"}, bus.alu_ctrl, 0);
        check({tag, " zlow"},     bus.zlow,     0);
        check({tag, " zhigh"},    bus.zhigh,    0);
        check({tag, " hi"},       bus.hi,       0);
        check({tag, " lo"},       bus.lo,       0);
        check({tag, " busy"},     bus.busy,     0);
        check({tag, " done"},     bus.done,     0);
        check({tag, " err"},      bus.err,      0);
    endtask

    // ---------------- driver ----------------
    // Issue one request, then follow it until busy drops. While busy it throws
    // random requests at the DUT, which must ignore them. With wiggle set, it
    // also drives a fresh ALU result every busy cycle. The value present at the
    // last busy edge is the one that should be captured.
    task automatic exec_op(input logic [11:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] zl, input logic [31:0] zh, input bit wiggle,
                           output int busy_cyc, output bit got_done, output bit got_err,
                           output bit stable, output logic [31:0] cap_zl, output logic [31:0] cap_zh);
        bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
        bus.zlow_in = zl; bus.zhigh_in = zh;
        cap_zl = zl; cap_zh = zh;
        busy_cyc = 0; stable = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) begin
            if (!bus.busy) break;
            busy_cyc++;
            if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_ctrl !== o || bus.done || bus.err)
                stable = 1'b0;
            bus.start = 1'($urandom_range(0, 1));
            bus.op    = 12'($urandom);
            bus.opa   = $urandom;
            bus.opb   = $urandom;
            if (wiggle) begin
                cap_zl = $urandom; cap_zh = $urandom;
                bus.zlow_in = cap_zl; bus.zhigh_in = cap_zh;
            end
            tick();
        end
        bus.start = 1'b0;
        got_done = bus.done;
        got_err  = bus.err;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [11:0] op;
        logic [31:0] a, b, zl, zh;
        int          busy;
        bit          err;
        logic [31:0] ezl, ezh, ehi, elo;
        logic [11:0] ectrl;
    } vec_t;

    vec_t vecs[8];

    int          bc;
    bit          gd, ge, st;
    logic [31:0] czl, czh;
    logic [31:0] m_zl, m_zh, m_hi, m_lo, m_a, m_b;
    logic [11:0] m_ctrl;
    bit          saw_done;
    logic [63:0] exp_z;

    initial begin
        //            op      a           b       zl          zh          busy err ezl         ezh         ehi         elo         ectrl
        vecs[0] = '{12'h001, 32'd5,      32'd7,  32'd12,     32'd0,      1, 0, 32'd12,     32'd0,      32'd0,      32'd0,      12'h001};
        vecs[1] = '{12'h004, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 4, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 12'h004};
        vecs[2] = '{12'h008, 32'd17,     32'd5,  32'd3,      32'd2,      4, 0, 32'd3,      32'd2,      32'd2,      32'd3,      12'h008};
        vecs[3] = '{12'h100, 32'hF0F0,   32'hFF00, 32'hF000,  32'd0,      1, 0, 32'hF000,   32'd0,      32'd2,      32'd3,      12'h100};
        vecs[4] = '{12'h003, 32'd99,     32'd98, 32'd77,     32'd66,     0, 1, 32'hF000,   32'd0,      32'd2,      32'd3,      12'h100};
        vecs[5] = '{12'h000, 32'd11,     32'd22, 32'd33,     32'd44,     0, 1, 32'hF000,   32'd0,      32'd2,      32'd3,      12'h100};
        vecs[6] = '{12'h800, 32'd0,      32'd0,  32'hFFFFFFFF, 32'd0,    1, 0, 32'hFFFFFFFF, 32'd0,    32'd2,      32'd3,      12'h800};
        vecs[7] = '{12'hC00, 32'd1,      32'd2,  32'd3,      32'd4,      0, 1, 32'hFFFFFFFF, 32'd0,    32'd2,      32'd3,      12'h800};

        bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0;
        bus.zlow_in = '0; bus.zhigh_in = '0;

        // Reset state.
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        clear = 1'b0;

        // Directed table. Row 0 starts on the first edge after clear is released.
        foreach (vecs[i]) begin
            exec_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].zl, vecs[i].zh, 1'b0, bc, gd, ge, st, czl, czh);
            check($sformatf("row%0d busy_cycles", i), bc, vecs[i].busy);
            check($sformatf("row%0d done", i), gd, !vecs[i].err);
            check($sformatf("row%0d err", i), ge, vecs[i].err);
            check($sformatf("row%0d stable", i), st, 1);
            check($sformatf("row%0d zlow", i), bus.zlow, vecs[i].ezl);
            check($sformatf("row%0d zhigh", i), bus.zhigh, vecs[i].ezh);
            check($sformatf("row%0d hi", i), bus.hi, vecs[i].ehi);
            check($sformatf("row%0d lo", i), bus.lo, vecs[i].elo);
            check($sformatf("row%0d alu_ctrl", i), bus.alu_ctrl, vecs[i].ectrl);
            tick();
            check($sformatf("row%0d pulses_clear", i), {bus.done, bus.err, bus.busy}, 0);
        end

        // MUL: a glitch on zlow_in in the middle of settling must not be captured.
        bus.start = 1'b1; bus.op = 12'h004; bus.opa = 32'hFFFFFFFF; bus.opb = 32'd2;
        bus.zlow_in = 32'hFFFFFFFE; bus.zhigh_in = 32'hFFFFFFFF;
        tick();                                   // accept edge, cycle 1
        bus.start = 1'b0;
        tick();                                   // cycle 2
        bus.zlow_in = 32'h12345678;
        tick();                                   // cycle 3
        bus.zlow_in = 32'hFFFFFFFE;
        check("mul_c3 done", bus.done, 0);
        tick();                                   // cycle 4
        check("mul_c4 busy", bus.busy, 1);
        check("mul_c4 done", bus.done, 0);
        tick();                                   // 4th edge after accept: captured
        check("mul done", bus.done, 1);
        check("mul busy", bus.busy, 0);
        check("mul zlow", bus.zlow, 32'hFFFFFFFE);
        check("mul hi", bus.hi, 32'hFFFFFFFF);
        check("mul lo", bus.lo, 32'hFFFFFFFE);

        // Back-to-back: start stays high through an ADD, so a SUB is taken in the done cycle.
        bus.start = 1'b1; bus.op = 12'h001; bus.opa = 32'd1; bus.opb = 32'd2;
        bus.zlow_in = 32'd3; bus.zhigh_in = 32'd0;
        tick();
        check("b2b add busy", bus.busy, 1);
        bus.op = 12'h002; bus.opa = 32'd9; bus.opb = 32'd4;
        tick();
        check("b2b add done", bus.done, 1);
        check("b2b add zlow", bus.zlow, 32'd3);
        check("b2b ignored ctrl", bus.alu_ctrl, 12'h001);
        check("b2b ignored a", bus.alu_a, 32'd1);
        tick();
        check("b2b sub busy", bus.busy, 1);
        check("b2b sub ctrl", bus.alu_ctrl, 12'h002);
        check("b2b sub a", bus.alu_a, 32'd9);
        bus.start = 1'b0; bus.zlow_in = 32'd5;
        tick();
        check("b2b sub done", bus.done, 1);
        check("b2b sub zlow", bus.zlow, 32'd5);
        tick();

        // Asynchronous clear in cycle 2 of a MUL.
        bus.start = 1'b1; bus.op = 12'h004; bus.opa = 32'd6; bus.opb = 32'd7;
        bus.zlow_in = 32'hAAAA5555; bus.zhigh_in = 32'h5555AAAA;
        tick();
        bus.start = 1'b0;
        tick();
        #2 clear = 1'b1;
        #1;
        check_all_zero("clear_async");
        tick();
        clear = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        check("clear no_done", saw_done, 0);
        check("clear zlow_kept", bus.zlow, 0);
        check("clear hi_kept", bus.hi, 0);
        exec_op(12'h001, 32'd20, 32'd22, 32'd42, 32'd0, 1'b0, bc, gd, ge, st, czl, czh);
        check("post_clear add busy", bc, 1);
        check("post_clear add done", gd, 1);
        check("post_clear add zlow", bus.zlow, 32'd42);
        tick();

        // Randomized ops against a transaction-level model.
        m_zl = bus.zlow; m_zh = bus.zhigh; m_hi = 32'd0; m_lo = 32'd0;
        m_a = 32'd20; m_b = 32'd22; m_ctrl = 12'h001;
        for (int it = 0; it < 60; it++) begin
            logic [11:0] o;
            logic [31:0] a, b;
            bit          valid, muldiv;
            o = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                              : 12'(1 << $urandom_range(0, 11));
            a = $urandom; b = $urandom;
            valid  = ($countones(o) == 1);
            muldiv = (o == 12'h004) || (o == 12'h008);
            exec_op(o, a, b, $urandom, $urandom, 1'b1, bc, gd, ge, st, czl, czh);
            if (valid) begin
                exp_q.push_back({czh, czl});
                m_zl = czl; m_zh = czh; m_a = a; m_b = b; m_ctrl = o;
                if (muldiv) begin
                    m_hi = czh; m_lo = czl;
                end
            end
            check($sformatf("rnd%0d busy_cycles", it), bc, valid ? (muldiv ? 4 : 1) : 0);
            check($sformatf("rnd%0d done", it), gd, valid);
            check($sformatf("rnd%0d err", it), ge, !valid);
            check($sformatf("rnd%0d stable", it), st, 1);
            if (gd && exp_q.size() > 0) begin
                exp_z = exp_q.pop_front();
                check($sformatf("rnd%0d z", it), {bus.zhigh, bus.zlow}, exp_z);
            end
            check($sformatf("rnd%0d zlow_model", it), bus.zlow, m_zl);
            check($sformatf("rnd%0d hi", it), bus.hi, m_hi);
            check($sformatf("rnd%0d lo", it), bus.lo, m_lo);
            check($sformatf("rnd%0d alu_ctrl", it), bus.alu_ctrl, m_ctrl);
            check($sformatf("rnd%0d alu_ab", it), {bus.alu_a, bus.alu_b}, {m_a, m_b});
            tick();
        end
        check("exp_q drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
